// File: rtl/msx_clk_pkg.sv
// rtl/msx_clk_pkg.sv - shared constants and retune state type for the MSX clock-enable generator
package msx_clk_pkg;

  localparam int unsigned ACC_W_DEF = 24;

  // Increments for a 21.477 MHz fabric clock: 2^24/6 and 2^24/12
  localparam logic [23:0] INC_3M58 = 24'h2AAAAB;
  localparam logic [23:0] INC_1M79 = 24'h155555;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } retune_st_e;

endpackage

// File: rtl/msx_clkena_div.sv
// rtl/msx_clkena_div.sv - modulo-N divider producing a registered pulse on every Nth tick
module msx_clkena_div #(
  parameter int unsigned N = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  output logic pulse_o
);

  localparam int unsigned  CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (tick_i) begin
      pulse_d = (cnt_q == LAST);
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/msx_clkena_gen.sv
// rtl/msx_clkena_gen.sv - phase-accumulator clock-enable generator with glitch-free retune
// Define MSX_CLKENA_CNT_EN to add the 32-bit cen_count output.
module msx_clkena_gen
  import msx_clk_pkg::*;
#(
  parameter int unsigned      ACC_W     = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RESET = ACC_W'(INC_3M58),
  parameter int unsigned      SUB_DIV   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_data,
  output logic             inc_ack,
  output logic             cen,
  output logic             cen_half,
  output logic             cen_sub,
`ifdef MSX_CLKENA_CNT_EN
  output logic [31:0]      cen_count,
`endif
  output logic [ACC_W-1:0] phase
);

  retune_st_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_act_q, inc_act_d;
  logic [ACC_W-1:0] inc_shd_q, inc_shd_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;
  logic             half_t_q;
  logic             cen_q, cen_half_q, inc_ack_q;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_act_q};
  assign carry = run & sum[ACC_W];
  assign acc_d = run ? sum[ACC_W-1:0] : acc_q;

  // Apply is evaluated before the write so a coinciding write lands in the shadow and stays pending
  always_comb begin
    state_d   = state_q;
    inc_shd_d = inc_shd_q;
    inc_act_d = inc_act_q;
    apply     = 1'b0;
    if ((state_q == ST_PEND) && (carry || !run)) begin
      apply     = 1'b1;
      inc_act_d = inc_shd_q;
      state_d   = ST_IDLE;
    end
    if (inc_wr) begin
      inc_shd_d = inc_data;
      state_d   = ST_PEND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      inc_act_q  <= INC_RESET;
      inc_shd_q  <= '0;
      half_t_q   <= 1'b0;
      cen_q      <= 1'b0;
      cen_half_q <= 1'b0;
      inc_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      inc_act_q  <= inc_act_d;
      inc_shd_q  <= inc_shd_d;
      half_t_q   <= half_t_q ^ carry;
      cen_q      <= carry;
      cen_half_q <= carry & half_t_q;
      inc_ack_q  <= apply;
    end
  end

  msx_clkena_div #(
    .N (SUB_DIV)
  ) u_sub_div (
    .clk_i   (clk),
    .rst_i   (reset),
    .tick_i  (carry),
    .pulse_o (cen_sub)
  );

`ifdef MSX_CLKENA_CNT_EN
  logic [31:0] cen_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cen_count_q <= '0;
    end else if (carry) begin
      cen_count_q <= cen_count_q + 32'd1;
    end
  end

  assign cen_count = cen_count_q;
`endif

  assign cen      = cen_q;
  assign cen_half = cen_half_q;
  assign inc_ack  = inc_ack_q;
  assign phase    = acc_q;

endmodule

// File: tb/tb_msx_clkena_gen.sv
// tb/tb_msx_clkena_gen.sv - table-driven scoreboard bench for msx_clkena_gen (ACC_W=8, SUB_DIV=4)
module tb_msx_clkena_gen;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         inc_wr = 1'b0;
  logic [W-1:0] inc_data = '0;
  logic         inc_ack, cen, cen_half, cen_sub;
  logic [W-1:0] phase;
`ifdef MSX_CLKENA_CNT_EN
  logic [31:0]  cen_count;
`endif

  msx_clkena_gen #(
    .ACC_W     (W),
    .INC_RESET (8'd64),
    .SUB_DIV   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .inc_wr   (inc_wr),
    .inc_data (inc_data),
    .inc_ack  (inc_ack),
    .cen      (cen),
    .cen_half (cen_half),
    .cen_sub  (cen_sub),
`ifdef MSX_CLKENA_CNT_EN
    .cen_count(cen_count),
`endif
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // outs = {inc_ack, cen_sub, cen_half, cen}
  typedef struct {
    bit         rst;
    bit         run;
    bit         wr;
    logic [7:0] data;
    logic [3:0] outs;
    logic [7:0] ph;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic vr(input bit rs, input bit r, input bit w, input int d, input logic [3:0] o, input int ph);
    vec_t e;
    e.rst  = rs;
    e.run  = r;
    e.wr   = w;
    e.data = 8'(d);
    e.outs = o;
    e.ph   = 8'(ph);
    vecs.push_back(e);
  endtask

  task automatic v(input bit r, input bit w, input int d, input logic [3:0] o, input int ph);
    vr(1'b0, r, w, d, o, ph);
  endtask

  function automatic logic [11:0] dut_out();
    return {inc_ack, cen_sub, cen_half, cen, phase};
  endfunction

  initial begin
    logic [11:0] got, exp;

    // Free-running at INC_RESET=64: cen every 4, half every 8, sub every 16
    for (int k = 1; k <= 16; k++)
      v(1, 0, 0, {1'b0, k % 16 == 0, k % 8 == 0, k % 4 == 0}, (64 * k) % 256);
    // Retune to 96: ack on next carry, then spacing 3,3,2
    v(1,1, 96,4'b0000, 64); v(1,0,0,4'b0000,128); v(1,0,0,4'b0000,192); v(1,0,0,4'b1001,  0);
    v(1,0,  0,4'b0000, 96); v(1,0,0,4'b0000,192); v(1,0,0,4'b0011, 32); v(1,0,0,4'b0000,128);
    v(1,0,  0,4'b0000,224); v(1,0,0,4'b0001, 64); v(1,0,0,4'b0000,160); v(1,0,0,4'b0111,  0);
    v(1,0,  0,4'b0000, 96); v(1,0,0,4'b0000,192); v(1,0,0,4'b0001, 32); v(1,0,0,4'b0000,128);
    v(1,0,  0,4'b0000,224); v(1,0,0,4'b0011, 64); v(1,0,0,4'b0000,160); v(1,0,0,4'b0001,  0);
    // Two writes before a carry: last (200) wins, single ack
    v(1,1, 32,4'b0000, 96); v(1,1,200,4'b0000,192); v(1,0,0,4'b1111, 32); v(1,0,0,4'b0000,232);
    v(1,0,  0,4'b0001,176); v(1,0,0,4'b0011,120); v(1,0,0,4'b0001, 64); v(1,0,0,4'b0111,  8);
    v(1,0,  0,4'b0000,208); v(1,0,0,4'b0001,152);
    // Write 128 on a carry cycle while idle: applies on the following carry
    v(1,1,128,4'b0011, 96); v(1,0,0,4'b1001, 40); v(1,0,0,4'b0000,168); v(1,0,0,4'b0111, 40);
    v(1,0,  0,4'b0000,168); v(1,0,0,4'b0001, 40);
    // Write coinciding with an apply: old shadow (64) applied, new (192) stays pending
    v(1,1, 64,4'b0000,168); v(1,1,192,4'b1011, 40); v(1,0,0,4'b0000,104); v(1,0,0,4'b0000,168);
    v(1,0,  0,4'b0000,232); v(1,0,0,4'b1001, 40); v(1,0,0,4'b0000,232); v(1,0,0,4'b0111,168);
    v(1,0,  0,4'b0001,104); v(1,0,0,4'b0011, 40); v(1,0,0,4'b0000,232);
    // Pending write then run=0 for 10 cycles: applies on first held cycle, phase frozen
    v(1,1, 64,4'b0001,168); v(0,0,0,4'b1000,168);
    for (int k = 0; k < 9; k++) v(0, 0, 0, 4'b0000, 168);
    v(1,0,  0,4'b0000,232); v(1,0,0,4'b0111, 40); v(1,0,0,4'b0000,104); v(1,0,0,4'b0000,168);
    v(1,0,  0,4'b0000,232); v(1,0,0,4'b0001, 40);
    // inc_act=0 freezes; a pending write then waits for run=0
    v(1,1,  0,4'b0000,104); v(1,0,0,4'b0000,168); v(1,0,0,4'b0000,232); v(1,0,0,4'b1011, 40);
    for (int k = 0; k < 4; k++) v(1, 0, 0, 4'b0000, 40);
    v(1,1,128,4'b0000, 40); v(1,0,0,4'b0000, 40); v(1,0,0,4'b0000, 40); v(0,0,0,4'b1000, 40);
    v(1,0,  0,4'b0000,168); v(1,0,0,4'b0001, 40); v(1,1,200,4'b0000,168);
    // Reset in PEND: pending 200 discarded, INC_RESET restored, no ack
    for (int k = 1; k <= 16; k++)
      vr(k == 1, 1, 0, 0, {1'b0, k % 16 == 0, k % 8 == 0, k % 4 == 0}, (64 * k) % 256);

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out()), 32'd0);
`ifdef MSX_CLKENA_CNT_EN
    check("reset_cen_count", cen_count, 32'd0);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        inc_wr = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_reset", 32'(dut_out()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", 32'(dut_out()), 32'd0);
`ifdef MSX_CLKENA_CNT_EN
        check("midrun_reset_cen_count", cen_count, 32'd0);
`endif
      end
      @(negedge clk);
      reset    = 1'b0;
      run      = vecs[i].run;
      inc_wr   = vecs[i].wr;
      inc_data = vecs[i].data;
      exp_q.push_back({vecs[i].outs, vecs[i].ph});
      @(posedge clk);
      #1;
      got = dut_out();
      exp = exp_q.pop_front();
      check($sformatf("vec%0d {ack,sub,half,cen,phase}", i), 32'(got), 32'(exp));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
